// File: rtl/flag_unit_pkg.sv
// Shared flag-word layout and operation encoding for the flag register stage.
// The ALU and microcode decode import the same bit positions.
package flag_unit_pkg;

    localparam int FL_N  = 15;
    localparam int FL_Z  = 14;
    localparam int FL_L  = 13;
    localparam int FL_V  = 12;
    localparam int FLAGW = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic l;
        logic v;
    } flags_t;

    // One winning operation per edge, already resolved by priority.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_WRITE,
        OP_SAVE,
        OP_RESTORE,
        OP_SWAP,
        OP_STROBE,
        OP_LOP
    } op_e;

    function automatic logic [15:0] flag_word(input flags_t f);
        logic [15:0] w;
        w       = '0;
        w[FL_N] = f.n;
        w[FL_Z] = f.z;
        w[FL_L] = f.l;
        w[FL_V] = f.v;
        return w;
    endfunction

    function automatic flags_t word_flags(input logic [15:0] w);
        return flags_t'({w[FL_N], w[FL_Z], w[FL_L], w[FL_V]});
    endfunction

endpackage

// File: rtl/flag_unit_if.sv
// Control/status bundle between the ALU/microcode side (master) and the flag unit (slave).
interface flag_unit_if;

    logic [15:0] alu_out;
    logic        nflstrobe;
    logic        fv;
    logic        nfltadd;
    logic        isroll;
    logic        roll16;
    logic        ncll;
    logic        ncpl;
    logic        nrflags;
    logic        nwflags;
    logic        nflsave;
    logic        nflrestore;
    logic        fl;
    logic        fv_q;
    logic        fn;
    logic        fz;
    logic        stk_err;

    modport master (
        output alu_out, nflstrobe, fv, nfltadd, isroll, roll16,
               ncll, ncpl, nrflags, nwflags, nflsave, nflrestore,
        input  fl, fv_q, fn, fz, stk_err
    );

    modport slave (
        input  alu_out, nflstrobe, fv, nfltadd, isroll, roll16,
               ncll, ncpl, nrflags, nwflags, nflsave, nflrestore,
        output fl, fv_q, fn, fz, stk_err
    );

endinterface

// File: rtl/flag_unit_stack.sv
// Depth-parameterised LIFO holding saved flag words; push/pop/swap on the top entry.
// Overflow/underflow requests are ignored here and reported by the caller via full/empty.
module flag_stack
    import flag_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   swap,
    input  flags_t din,
    output flags_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    flags_t          mem [DEPTH];
    logic [PW-1:0]   sp;
    logic [AW-1:0]   top;

    assign top   = AW'(sp - PW'(1));
    assign full  = (sp == PW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = mem[top];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    // NOTE: the storage array has no reset; only the pointer defines validity,
    // which keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[AW-1:0]] <= din;
        end else if (swap && !empty) begin
            mem[top] <= din;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Flag register stage behind the ALU: N/Z/L/V registers, microcoded L ops,
// IBUS flag-word access and a save/restore stack for interrupt entry/exit.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    flag_unit_if.slave  bus,
    inout  wire  [15:0] ibus
);

    flags_t flags_q;
    flags_t flags_d;
    flags_t stk_dout;
    op_e    op;
    logic   stk_full;
    logic   stk_empty;
    logic   stk_err_q;
    logic   stk_err_d;

    // Priority: ibus write > stack > ALU strobe > L ops; losers are dropped.
    always_comb begin
        op = OP_NONE;
        if (!bus.nwflags) begin
            op = OP_WRITE;
        end else if (!bus.nflsave && !bus.nflrestore) begin
            op = OP_SWAP;
        end else if (!bus.nflsave) begin
            op = OP_SAVE;
        end else if (!bus.nflrestore) begin
            op = OP_RESTORE;
        end else if (!bus.nflstrobe) begin
            op = OP_STROBE;
        end else if (!bus.ncll || !bus.ncpl) begin
            op = OP_LOP;
        end
    end

    // NOTE: defaults at the top of the block guarantee every path assigns,
    // so no latch is inferred.
    always_comb begin
        flags_d   = flags_q;
        stk_err_d = stk_err_q;
        case (op)
            OP_WRITE: flags_d = word_flags(ibus);
            OP_SAVE: begin
                if (stk_full) stk_err_d = 1'b1;
            end
            OP_RESTORE, OP_SWAP: begin
                if (stk_empty) stk_err_d = 1'b1;
                else           flags_d   = stk_dout;
            end
            OP_STROBE: begin
                flags_d.n = bus.alu_out[15];
                flags_d.z = (bus.alu_out == 16'h0000);
                flags_d.v = bus.fv;
                flags_d.l = bus.isroll ? bus.roll16 : (flags_q.l ^ ~bus.nfltadd);
            end
            OP_LOP: begin
                case ({bus.ncll, bus.ncpl})
                    2'b00:   flags_d.l = 1'b1;
                    2'b01:   flags_d.l = 1'b0;
                    2'b10:   flags_d.l = ~flags_q.l;
                    default: flags_d.l = flags_q.l;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= '0;
            stk_err_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            stk_err_q <= stk_err_d;
        end
    end

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (op == OP_SAVE),
        .pop   (op == OP_RESTORE),
        .swap  (op == OP_SWAP),
        .din   (flags_q),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign ibus        = bus.nrflags ? 16'bz : flag_word(flags_q);
    assign bus.fn      = flags_q.n;
    assign bus.fz      = flags_q.z;
    assign bus.fl      = flags_q.l;
    assign bus.fv_q    = flags_q.v;
    assign bus.stk_err = stk_err_q;

endmodule
